// File: rtl/ibuf_skew_pp_pkg.sv
// rtl/ibuf_skew_pp_pkg.sv - shared types and helpers for the skewed input buffer
package ibuf_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY,
      BANK_FULL,
      BANK_STREAM
   } bank_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_FIN
   } stream_state_t;

   // Width of the skew step counter, which runs 0..2N-2.
   function automatic int skew_w(input int n);
      return $clog2(2 * n - 1);
   endfunction

endpackage

// File: rtl/ibuf_skew_pp_if.sv
// rtl/ibuf_skew_pp_if.sv - load/stream bus between the loader, the buffer and the MAC array
interface ibuf_skew_pp_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int TW = 4,
   parameter int AW = $clog2(N)
);
   logic            LOAD_EN;
   logic [AW-1:0]   IDST;
   logic [N*DW-1:0] IWord;
   logic            LOAD_DONE;
   logic [TW-1:0]   ODST_i;
   logic            START_CALC;
   logic            LOAD_READY;
   logic            CALC_READY;
   logic            BUSY;
   logic [N*DW-1:0] IROW_o;
   logic [N-1:0]    ICOL_VALID;
   logic [TW-1:0]   ODST_o;
   logic            DONE;
   logic            ERR;

   modport master (
      output LOAD_EN, IDST, IWord, LOAD_DONE, ODST_i, START_CALC,
      input  LOAD_READY, CALC_READY, BUSY, IROW_o, ICOL_VALID, ODST_o, DONE, ERR
   );

   modport slave (
      input  LOAD_EN, IDST, IWord, LOAD_DONE, ODST_i, START_CALC,
      output LOAD_READY, CALC_READY, BUSY, IROW_o, ICOL_VALID, ODST_o, DONE, ERR
   );
endinterface

// File: rtl/ibuf_skew_pp_bank.sv
// rtl/ibuf_skew_pp_bank.sv - one N-row matrix bank with a row write port and per-lane column reads
module ibuf_bank #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = $clog2(N)
) (
   input  logic            CLK,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [N*DW-1:0] wdata,
   input  logic [N*AW-1:0] rd_row,
   output logic [N*DW-1:0] rd_data
);
   logic [N*DW-1:0] mem [N];

   // Row write; contents are never cleared, so unwritten rows keep stale data.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Lane j reads element j of the row it currently needs.
   for (genvar j = 0; j < N; j++) begin : g_lane
      assign rd_data[j*DW +: DW] = mem[rd_row[j*AW +: AW]][j*DW +: DW];
   end
endmodule

// File: rtl/ibuf_skew_pp.sv
// rtl/ibuf_skew_pp.sv - double-buffered matrix loader streaming a diagonally skewed wavefront
module ibuf_skew_pp
   import ibuf_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int TW = 4,
   parameter int AW = $clog2(N)
) (
   input logic           CLK,
   input logic           RSTN,
   ibuf_skew_pp_if.slave bus
);
   localparam int SW = skew_w(N);
   localparam logic [SW-1:0] T_LAST = SW'(2 * N - 2);

   bank_state_t     bank_st   [2];
   bank_state_t     bank_st_n [2];
   logic            wr_bank, wr_bank_n, rd_bank, rd_bank_n;
   stream_state_t   fsm, fsm_n;
   logic [SW-1:0]   t_cnt, t_cnt_n;
   logic [TW-1:0]   tag [2];

   logic            load_ready_q, calc_ready_q, busy_q, done_q, err_q;
   logic [N*DW-1:0] irow_q;
   logic [N-1:0]    icol_q;
   logic [TW-1:0]   odst_q;

   logic            idst_ok, ld_ok, cm_ok, st_ok, err_ev;
   logic [N*AW-1:0] rd_row;
   logic [N-1:0]    lane_vld;
   logic [N*DW-1:0] rd_data0, rd_data1, rd_data, irow_n;

   assign idst_ok = {1'b0, bus.IDST} < (AW+1)'(N);
   assign ld_ok   = bus.LOAD_EN & load_ready_q & idst_ok;
   assign cm_ok   = bus.LOAD_DONE & load_ready_q;
   assign st_ok   = bus.START_CALC & calc_ready_q;
   assign err_ev  = (bus.LOAD_EN & ~(load_ready_q & idst_ok))
                  | (bus.LOAD_DONE & ~load_ready_q)
                  | (bus.START_CALC & ~calc_ready_q);

   ibuf_bank #(.N(N), .DW(DW), .AW(AW)) u_bank0 (
      .CLK(CLK), .we(ld_ok & ~wr_bank), .waddr(bus.IDST), .wdata(bus.IWord),
      .rd_row(rd_row), .rd_data(rd_data0)
   );

   ibuf_bank #(.N(N), .DW(DW), .AW(AW)) u_bank1 (
      .CLK(CLK), .we(ld_ok & wr_bank), .waddr(bus.IDST), .wdata(bus.IWord),
      .rd_row(rd_row), .rd_data(rd_data1)
   );

   // Skew decode: lane j is live for steps j..j+N-1 and reads row t-j.
   always_comb begin
      int d;
      d        = 0;
      rd_row   = '0;
      lane_vld = '0;
      for (int j = 0; j < N; j++) begin
         d = int'(t_cnt) - j;
         if (d >= 0 && d < N) begin
            lane_vld[j]           = 1'b1;
            rd_row[j*AW +: AW]    = AW'(d);
         end
      end
   end

   // Select the streaming bank and zero the lanes outside the wavefront.
   always_comb begin
      rd_data = rd_bank ? rd_data1 : rd_data0;
      irow_n  = '0;
      for (int j = 0; j < N; j++) begin
         if (lane_vld[j]) begin
            irow_n[j*DW +: DW] = rd_data[j*DW +: DW];
         end
      end
   end

   // Next bank states, pointers and stream FSM; commit and free always hit different banks.
   always_comb begin
      bank_st_n[0] = bank_st[0];
      bank_st_n[1] = bank_st[1];
      wr_bank_n    = wr_bank;
      rd_bank_n    = rd_bank;
      fsm_n        = fsm;
      t_cnt_n      = t_cnt;
      if (cm_ok) begin
         bank_st_n[wr_bank] = BANK_FULL;
         wr_bank_n          = ~wr_bank;
      end
      case (fsm)
         ST_IDLE: begin
            if (st_ok) begin
               bank_st_n[rd_bank] = BANK_STREAM;
               fsm_n              = ST_STREAM;
               t_cnt_n            = '0;
            end
         end
         ST_STREAM: begin
            if (t_cnt == T_LAST) begin
               fsm_n = ST_FIN;
            end else begin
               t_cnt_n = t_cnt + 1'b1;
            end
         end
         ST_FIN: begin
            bank_st_n[rd_bank] = BANK_EMPTY;
            rd_bank_n          = ~rd_bank;
            if (st_ok) begin
               bank_st_n[~rd_bank] = BANK_STREAM;
               fsm_n               = ST_STREAM;
               t_cnt_n             = '0;
            end else begin
               fsm_n = ST_IDLE;
            end
         end
         default: fsm_n = ST_IDLE;
      endcase
   end

   // State update and registered outputs; readies are derived from next state so they track the edge.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         bank_st[0]   <= BANK_EMPTY;
         bank_st[1]   <= BANK_EMPTY;
         wr_bank      <= 1'b0;
         rd_bank      <= 1'b0;
         fsm          <= ST_IDLE;
         t_cnt        <= '0;
         tag[0]       <= '0;
         tag[1]       <= '0;
         load_ready_q <= 1'b1;
         calc_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         irow_q       <= '0;
         icol_q       <= '0;
         odst_q       <= '0;
      end else begin
         bank_st      <= bank_st_n;
         wr_bank      <= wr_bank_n;
         rd_bank      <= rd_bank_n;
         fsm          <= fsm_n;
         t_cnt        <= t_cnt_n;
         if (cm_ok) begin
            tag[wr_bank] <= bus.ODST_i;
         end
         load_ready_q <= (bank_st_n[wr_bank_n] == BANK_EMPTY);
         calc_ready_q <= ((fsm_n == ST_IDLE) && (bank_st_n[rd_bank_n] == BANK_FULL))
                       | ((fsm_n == ST_FIN) && (bank_st_n[~rd_bank_n] == BANK_FULL));
         busy_q       <= (fsm_n == ST_STREAM);
         done_q       <= (fsm == ST_FIN);
         err_q        <= err_q | err_ev;
         irow_q       <= (fsm == ST_STREAM) ? irow_n : '0;
         icol_q       <= (fsm == ST_STREAM) ? lane_vld : '0;
         odst_q       <= (fsm_n == ST_IDLE) ? '0 : tag[rd_bank_n];
      end
   end

   assign bus.LOAD_READY = load_ready_q;
   assign bus.CALC_READY = calc_ready_q;
   assign bus.BUSY       = busy_q;
   assign bus.IROW_o     = irow_q;
   assign bus.ICOL_VALID = icol_q;
   assign bus.ODST_o     = odst_q;
   assign bus.DONE       = done_q;
   assign bus.ERR        = err_q;
endmodule

// File: doc/ibuf_skew_pp.md
# ibuf_skew_pp

Parametrised, double-buffered input skew buffer that feeds an N×N systolic MAC array. It accepts an N×N input matrix one row-word per cycle into a load bank. While it loads one bank, it streams the other bank as a diagonally skewed wavefront: lane j is delayed by j cycles, and per-lane valids are generated alongside the data. It sits between the input-loading datapath and the MAC array, and carries a destination tag alongside each matrix.

## Interface
- N, default 4: array dimension (rows, columns, lanes); N ≥ 2.
- DW, default 8: element width in bits.
- TW, default 4: destination-tag width.
- AW, default $clog2(N): row-index width.

- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- LOAD_EN  in  1  write IWord into row IDST of the current load bank.
- IDST  in  AW  destination row index.
- IWord  in  N*DW  row data; element c occupies IWord[c*DW +: DW].
- LOAD_DONE  in  1  pulse; commits the load bank and captures ODST_i.
- ODST_i  in  TW  tag captured with the matrix at LOAD_DONE.
- START_CALC  in  1  pulse; starts streaming the oldest committed bank.
- LOAD_READY  out  1  load bank is EMPTY (writable).
- CALC_READY  out  1  the stream FSM can accept START_CALC and the read bank is FULL.
- BUSY  out  1  stream FSM is in STREAM.
- IROW_o  out  N*DW  skewed lane data; lane j is IROW_o[j*DW +: DW].
- ICOL_VALID  out  N  per-lane valid.
- ODST_o  out  TW  tag of the streaming bank.
- DONE  out  1  one-cycle end-of-matrix pulse.
- ERR  out  1  sticky protocol-error flag.

## Operation
- Storage: two banks, each N rows × N*DW bits.
  - Each bank has a state of EMPTY, FULL or STREAM.
  - wr_bank and rd_bank pointers both reset to 0.
- Load path:
  - LOAD_EN with LOAD_READY=1 and IDST<N writes the row.
  - Unwritten rows keep stale contents; banks are never cleared.
  - LOAD_DONE with LOAD_READY=1 sets the bank to FULL, stores ODST_i and toggles wr_bank.
  - LOAD_EN and LOAD_DONE in the same cycle: the write lands first, then the commit includes it.
- Stream FSM states: IDLE, STREAM, FIN.
  - IDLE→STREAM on START_CALC & CALC_READY; the bank goes to STREAM and the counter t=0.
  - STREAM increments t each cycle; at t=2N-2 it goes to FIN.
  - FIN lasts one cycle: DONE=1, bank←EMPTY, rd_bank toggles, then the FSM returns to IDLE.
  - CALC_READY is high in IDLE and FIN when the next rd bank is FULL.
  - START_CALC accepted in FIN goes FIN→STREAM directly, so back-to-back matrices have one non-valid cycle between them.
- Skew rule at stream step t:
  - ICOL_VALID[j] = (j ≤ t ≤ j+N-1).
  - Lane j carries M[t-j][j] when valid, else 0.
- ODST_o equals the bank tag during STREAM/FIN, and 0 otherwise.
- ERR is set, and the offending action is ignored, on any of:
  - LOAD_EN or LOAD_DONE while LOAD_READY=0.
  - LOAD_EN with IDST≥N.
  - START_CALC while CALC_READY=0.
- ERR is cleared only by reset.
- Load and stream banks are always distinct. A commit and a free in the same cycle touch different banks and both take effect.

## Timing
- Reset (RSTN=0 at an edge):
  - Outputs after that edge: IROW_o=0, ICOL_VALID=0, ODST_o=0, DONE=0, BUSY=0, ERR=0, CALC_READY=0, LOAD_READY=1.
  - Both banks go EMPTY, FSM goes IDLE, both pointers go to 0.
  - This applies mid-load and mid-stream; any in-flight matrix is discarded.
- All outputs are registered.
- START_CALC sampled at edge k:
  - Step t is visible after edge k+1+t, for t=0..2N-2.
  - DONE is visible after edge k+2N.
  - LOAD_READY rises after edge k+2N if that bank was blocking.
- LOAD_READY/CALC_READY update the cycle after the commit or free edge.
- Throughput: one matrix per 2N cycles when loads keep pace.

## Structure
- Shared package ibuf_pkg holds:
  - bank_state_t {EMPTY, FULL, STREAM}.
  - stream_state_t {IDLE, STREAM, FIN}.
  - Skew-count width helper $clog2(2N-1).
- Sub-module ibuf_bank: one bank's row register array with a write port and N per-lane column reads (row index, lane). It is instantiated twice.
- Top level holds the pointers, bank states, tags, FSM, skew counter and output registers.

## Test plan
- Reset: hold RSTN=0 for 2 cycles → all outputs 0, LOAD_READY=1, CALC_READY=0, ERR=0.
- Single matrix, N=4, DW=8, M[r][c]=0x10(r+1)+c (row 0 IWord=0x13121110), ODST_i=5, then START_CALC.
  - t=0: ICOL_VALID=0001, IROW_o=0x00000010.
  - t=1: 0011, 0x00001120.
  - t=3: 1111, 0x13223140.
  - t=6: 1000, 0x43000000.
  - ODST_o=5 throughout, then DONE for 1 cycle.
- Ping-pong: load bank 1 while bank 0 streams; START_CALC during DONE → second stream t=0 appears 1 cycle after DONE, and the second matrix's data is correct.
- Errors, each checked separately:
  - Commit two matrices, then a third LOAD_DONE → ERR=1 and stored data unchanged.
  - START_CALC with no FULL bank → ERR=1 and no valids.
- Reset at t=3 → next cycle ICOL_VALID=0, BUSY=0, DONE=0, LOAD_READY=1; a new load then stream from bank 0 is correct.
- N=8, DW=16 → 15 stream steps; lane 7 valid at t=7..14; lane 0 valid at t=0..7; DONE after edge k+16.
